// File: rtl/nibble_decoder.sv
// nibble_decoder: rebuilds 4-bit words from a stream of 3-bit symbols.
//   Pair mode (select=0):   a hi symbol {1,hi[1:0]} followed by a lo symbol {0,lo[1:0]}
//                           gives data_out = {hi, lo}.
//   Expand mode (select=1): one index symbol gives a one-hot word,
//                           or zero when sym_in[2] is clear.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   sym_in/sym_valid/      symbol input stream (valid/ready handshake)
//   sym_ready
//   select                 mode for a new word, sampled on the word's first symbol
//   data_out/sel_out/      decoded word stream (valid/ready handshake)
//   data_valid/data_ready
//   err_cnt                saturating count of protocol errors
//   word_cnt               wrapping count of emitted words
module nibble_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             select,
  output logic [3:0]       data_out,
  output logic             sel_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [0:0] {StIdle, StHaveHi} state_e;

  state_e           state_q, state_d;
  logic [1:0]       hi_q, hi_d;
  logic [3:0]       data_q, data_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic accept;
  logic emit;
  logic err;

  // Only a pending, unaccepted word stalls the input side; errors never do.
  assign sym_ready = !valid_q || data_ready;
  assign accept    = sym_valid && sym_ready;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    data_d  = data_q;
    sel_d   = sel_q;
    emit    = 1'b0;
    err     = 1'b0;

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (select) begin
            emit   = 1'b1;
            sel_d  = 1'b1;
            data_d = sym_in[2] ? (4'b0001 << sym_in[1:0]) : 4'b0000;
          end else if (sym_in[2]) begin
            hi_d    = sym_in[1:0];
            state_d = StHaveHi;
          end else begin
            err = 1'b1;
          end
        end
        StHaveHi: begin
          // select is ignored here: only pair mode can reach this state.
          if (!sym_in[2]) begin
            emit    = 1'b1;
            sel_d   = 1'b0;
            data_d  = {hi_q, sym_in[1:0]};
            state_d = StIdle;
          end else begin
            // Resync: a second hi symbol replaces the stored one.
            err  = 1'b1;
            hi_d = sym_in[1:0];
          end
        end
        default: state_d = StIdle;
      endcase
    end

    valid_d = emit || (valid_q && !data_ready);

    word_cnt_d = emit ? word_cnt_q + CNT_W'(1) : word_cnt_q;
    err_cnt_d  = (err && (err_cnt_q != {CNT_W{1'b1}})) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hi_q       <= 2'b00;
      data_q     <= 4'b0000;
      sel_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign data_out   = data_q;
  assign sel_out    = sel_q;
  assign data_valid = valid_q;
  assign err_cnt    = err_cnt_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_nibble_decoder.sv
// Testbench for nibble_decoder: directed symbol vectors with hand-computed expected words.
// Expected {sel_out, data_out} values are queued when stimulus is issued; a monitor pops and
// compares each word as the consumer takes it.
module tb_nibble_decoder;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [2:0]       sym_in;
  logic             sym_valid;
  logic             sym_ready;
  logic             select;
  logic [3:0]       data_out;
  logic             sel_out;
  logic             data_valid;
  logic             data_ready;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] word_cnt;

  nibble_decoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .select    (select),
    .data_out  (data_out),
    .sel_out   (sel_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a word is consumed on the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got sel=%b data=%b expected none", sel_out, data_out);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("word", {27'd0, sel_out, data_out}, {27'd0, e});
      end
    end
  end

  // Present one symbol and hold it until the handshake completes.
  task automatic send(input logic [2:0] s, input logic sel);
    int guard;
    guard = 0;
    sym_in = s; select = sel; sym_valid = 1'b1;
    while (!sym_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!sym_ready) begin
      n_checks++;
      $display("FAIL send_timeout: sym_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic expand(input logic [2:0] s);
    logic [3:0] w;
    w = s[2] ? (4'b0001 << s[1:0]) : 4'b0000;
    exp_q.push_back({1'b1, w});
    send(s, 1'b1);
  endtask

  task automatic pair(input logic [3:0] v);
    exp_q.push_back({1'b0, v});
    send({1'b1, v[3:2]}, 1'b0);
    send({1'b0, v[1:0]}, 1'b0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    data_ready = 1'b1;
    while ((exp_q.size() != 0 || data_valid) && g < 200) begin
      @(posedge clk); #1; g++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    sym_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int base;

  initial begin
    rst_n = 1'b0; sym_in = '0; sym_valid = 1'b0; select = 1'b0; data_ready = 1'b1;
    #2;
    check("rst_data_valid", data_valid, 0);
    check("rst_sym_ready", sym_ready, 1);
    check("rst_data_out", data_out, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Expand mode: each word appears on the accepting edge.
    expand(3'b100); check("exp_lat0", {data_valid, data_out}, 5'b1_0001);
    expand(3'b101); check("exp_lat1", {data_valid, data_out}, 5'b1_0010);
    expand(3'b110); check("exp_lat2", {data_valid, data_out}, 5'b1_0100);
    expand(3'b111); check("exp_lat3", {data_valid, data_out}, 5'b1_1000);
    expand(3'b000); check("exp_lat4", {data_valid, data_out}, 5'b1_0000);
    check("exp_word_cnt", word_cnt, 5);
    drain();

    // Pair mode basic and full sweep.
    do_reset();
    pair(4'b1001);
    drain();
    check("pair_err_cnt", err_cnt, 0);
    check("pair_word_cnt", word_cnt, 1);
    for (int v = 0; v < 16; v++) pair(4'(v));
    drain();
    check("sweep_word_cnt", word_cnt, 17);

    // Protocol errors: lo in IDLE dropped, repeated hi resyncs.
    do_reset();
    send(3'b011, 1'b0);
    @(posedge clk); #1;
    check("err_idle_cnt", err_cnt, 1);
    check("err_idle_no_word", {data_valid, word_cnt}, 0);
    send(3'b101, 1'b0);
    send(3'b111, 1'b1); // select ignored in HAVE_HI
    exp_q.push_back({1'b0, 4'b1100});
    send(3'b000, 1'b0);
    drain();
    check("err_resync_cnt", err_cnt, 2);

    // Backpressure: word held, no symbol accepted, nothing lost.
    do_reset();
    data_ready = 1'b0;
    expand(3'b101);
    sym_in = 3'b110; select = 1'b1; sym_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_sym_ready", sym_ready, 0);
      check("bp_hold", {data_valid, sel_out, data_out}, 6'b1_1_0010);
    end
    check("bp_word_cnt", word_cnt, 1);
    exp_q.push_back({1'b1, 4'b0100});
    data_ready = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    drain();
    check("bp_after_word_cnt", word_cnt, 2);

    // Mid-word reset discards stored hi.
    send(3'b111, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_outputs", {data_valid, sel_out, data_out, sym_ready}, 7'b0_0_0000_1);
    check("mid_rst_counters", {err_cnt, word_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(3'b010, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_err", err_cnt, 1);
    check("mid_rst_no_word", {data_valid, word_cnt}, 0);

    // Saturation and wrap.
    do_reset();
    for (int i = 0; i < 300; i++) send(3'b000, 1'b0);
    check("err_sat", err_cnt, 255);
    for (int i = 0; i < 257; i++) expand(3'(4 + (i % 4)));
    drain();
    check("word_wrap", word_cnt, 1);
    check("err_sat_hold", err_cnt, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
